// File: rtl/nibble_adder_scheduler.sv
// rtl/nibble_adder_scheduler.sv - two-requester wide adder sequenced through one 4-bit CLA slice
// Round-robin arbitration, operand capture, then one nibble per cycle LSB first with chained carry.

module nibble_cla (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Carries expanded in lookahead form so no carry depends on a lower computed carry.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

module nibble_adder_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic [1:0]       grant_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             done_id_o,
  output logic [WIDTH:0]   sum_o
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ADD  = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic             win;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c;
  logic [WIDTH-1:0] part_ins;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    case (req_i)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        nib_a = op_a_q[4*k +: 4];
        nib_b = op_b_q[4*k +: 4];
      end
    end
  end

  nibble_cla u_slice (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_c)
  );

  always_comb begin
    part_ins = part_q;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        part_ins[4*k +: 4] = nib_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    part_d    = part_q;
    last_d    = last_q;
    grant_d   = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d = S_ADD;
          op_a_d  = win ? a1_i : a0_i;
          op_b_d  = win ? b1_i : b0_i;
          idx_d   = '0;
          carry_d = 1'b0;
          last_d  = win;
          grant_d = win ? 2'b10 : 2'b01;
        end
      end
      S_ADD: begin
        part_d  = part_ins;
        carry_d = nib_c;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          // last_q still names the requester captured for this operation.
          state_d   = S_IDLE;
          idx_d     = '0;
          sum_d     = {nib_c, part_ins};
          done_d    = 1'b1;
          done_id_d = last_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      part_q    <= '0;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      part_q    <= part_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q == S_ADD);
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign sum_o     = sum_q;
endmodule

// File: tb/tb_nibble_adder_scheduler.sv
// tb/tb_nibble_adder_scheduler.sv - directed table and sequence checks for nibble_adder_scheduler

module tb_nibble_adder_scheduler;
  logic        clk;
  logic        rst;

  logic [1:0]  req;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  grant;
  logic        busy, done, done_id;
  logic [16:0] sum;

  logic [1:0]  req4;
  logic [3:0]  a04, b04, a14, b14;
  logic [1:0]  grant4;
  logic        busy4, done4, done_id4;
  logic [4:0]  sum4;

  int checks = 0;
  int errors = 0;
  logic model_last;

  nibble_adder_scheduler #(.WIDTH(16)) dut16 (
    .clock_i(clk), .reset_i(rst), .req_i(req),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .grant_o(grant), .busy_o(busy), .done_o(done), .done_id_o(done_id), .sum_o(sum)
  );

  nibble_adder_scheduler #(.WIDTH(4)) dut4 (
    .clock_i(clk), .reset_i(rst), .req_i(req4),
    .a0_i(a04), .b0_i(b04), .a1_i(a14), .b1_i(b14),
    .grant_o(grant4), .busy_o(busy4), .done_o(done4), .done_id_o(done_id4), .sum_o(sum4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  grant;
    logic [16:0] sum;
    logic        id;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One 16-bit operation: request, grant cycle, N-1 busy cycles, done cycle.
  task automatic do_op16(input logic [1:0] rq, input logic [15:0] xa0, input logic [15:0] xb0,
                         input logic [15:0] xa1, input logic [15:0] xb1,
                         input logic [1:0] eg, input logic [16:0] es, input logic eid);
    @(negedge clk);
    req = rq; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    @(posedge clk); #1;
    check("grant", 32'(grant), 32'(eg));
    check("busy_in_grant", 32'(busy), 32'd1);
    check("done_in_grant", 32'(done), 32'd0);
    @(negedge clk);
    req = 2'b00;
    a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
      check("done_early", 32'(done), 32'd0);
      check("busy_mid", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    check("done", 32'(done), 32'd1);
    check("sum", 32'(sum), 32'(es));
    check("done_id", 32'(done_id), 32'(eid));
    check("busy_at_done", 32'(busy), 32'd0);
    check("grant_at_done", 32'(grant), 32'd0);
  endtask

  initial begin
    logic [1:0]  rq, eg;
    logic [15:0] ra0, rb0, ra1, rb1;
    logic [16:0] es;
    logic        w;

    vecs[0] = '{2'b01, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'b01, 17'h10000, 1'b0};
    vecs[1] = '{2'b10, 16'h0000, 16'h0000, 16'h1234, 16'h4321, 2'b10, 17'h05555, 1'b1};
    vecs[2] = '{2'b11, 16'h8000, 16'h8000, 16'h0001, 16'h0002, 2'b01, 17'h10000, 1'b0};
    vecs[3] = '{2'b11, 16'h1111, 16'h2222, 16'hABCD, 16'h1234, 2'b10, 17'h0BE01, 1'b1};
    vecs[4] = '{2'b11, 16'h0F0F, 16'h00F1, 16'h5555, 16'h5555, 2'b01, 17'h01000, 1'b0};
    vecs[5] = '{2'b01, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 2'b01, 17'h00000, 1'b0};
    vecs[6] = '{2'b11, 16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 2'b10, 17'h1FFFE, 1'b1};
    vecs[7] = '{2'b10, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8001, 2'b10, 17'h10000, 1'b1};

    rst = 1'b1; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    req4 = 2'b00; a04 = '0; b04 = '0; a14 = '0; b14 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=4: two-cycle latency, busy for a single cycle.
    @(negedge clk);
    req4 = 2'b01; a04 = 4'hF; b04 = 4'hF;
    @(posedge clk); #1;
    check("w4_grant", 32'(grant4), 32'd1);
    check("w4_busy1", 32'(busy4), 32'd1);
    check("w4_done_early", 32'(done4), 32'd0);
    @(negedge clk);
    req4 = 2'b11; a04 = 4'h3; b04 = 4'h4; a14 = 4'h8; b14 = 4'h8;
    @(posedge clk); #1;
    check("w4_done", 32'(done4), 32'd1);
    check("w4_sum", 32'(sum4), 32'h1E);
    check("w4_busy2", 32'(busy4), 32'd0);
    @(posedge clk); #1;
    check("w4_tie_grant", 32'(grant4), 32'd2);
    @(negedge clk);
    req4 = 2'b00;
    @(posedge clk); #1;
    check("w4_tie_done", 32'(done4), 32'd1);
    check("w4_tie_sum", 32'(sum4), 32'h10);
    check("w4_tie_id", 32'(done_id4), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_op16(vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
              vecs[i].grant, vecs[i].sum, vecs[i].id);
    end

    // req=11 held: grants alternate every 5 cycles, starting with requester 0.
    @(negedge clk);
    req = 2'b11; a0 = 16'h0102; b0 = 16'h0304; a1 = 16'hF000; b1 = 16'h1000;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      eg = (c % 5 == 1) ? ((c == 6) ? 2'b10 : 2'b01) : 2'b00;
      check("held_grant", 32'(grant), 32'(eg));
      check("held_done", 32'(done), (c % 5 == 0) ? 32'd1 : 32'd0);
      if (c % 5 == 0) begin
        check("held_id", 32'(done_id), (c == 10) ? 32'd1 : 32'd0);
        check("held_sum", 32'(sum), (c == 10) ? 32'h10000 : 32'h00406);
      end
      if (c == 15) begin
        @(negedge clk);
        req = 2'b00;
      end
    end

    // Reset in the third cycle of an operation aborts it.
    @(negedge clk);
    req = 2'b01; a0 = 16'hFFFF; b0 = 16'hFFFF;
    @(posedge clk); #1;
    check("abort_grant", 32'(grant), 32'd1);
    @(negedge clk);
    req = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_grant0", 32'(grant), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    do_op16(2'b11, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 2'b01, 17'h00002, 1'b0);
    model_last = 1'b0;

    for (int i = 0; i < 12; i++) begin
      rq  = 2'($urandom_range(1, 3));
      ra0 = 16'($urandom); rb0 = 16'($urandom);
      ra1 = 16'($urandom); rb1 = 16'($urandom);
      w   = (rq == 2'b01) ? 1'b0 : (rq == 2'b10) ? 1'b1 : ~model_last;
      eg  = w ? 2'b10 : 2'b01;
      es  = w ? ({1'b0, ra1} + {1'b0, rb1}) : ({1'b0, ra0} + {1'b0, rb0});
      model_last = w;
      do_op16(rq, ra0, rb0, ra1, rb1, eg, es, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
